bus_timer: RTL and testbench

Memory-mapped 32-bit reload timer on the processor data bus, occupying the peripheral window below the LED/7-segment/UART registers. It counts TL up from TH, reloads on overflow and raises a level interrupt to the pipeline's exception logic. Its `Read_data` is zero when not addressed, so the bus read multiplexer ORs or selects it alongside DataMemory and UART data.

---
 rtl/bus_timer_pkg.sv | 16 +
 rtl/timer_prescaler.sv | 36 +++
 rtl/bus_timer.sv | 105 ++++++++++
 tb/tb_bus_timer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/bus_timer_pkg.sv
// Shared constants for the memory-mapped reload timer.
package bus_timer_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h4000_0000;

    // Byte offsets of the registers from the base address
    localparam logic [31:0] TH_OFF   = 32'd0;
    localparam logic [31:0] TL_OFF   = 32'd4;
    localparam logic [31:0] TCON_OFF = 32'd8;

    // TCON bit positions
    localparam int EN_BIT     = 0;
    localparam int IRQEN_BIT  = 1;
    localparam int STATUS_BIT = 2;

endpackage

// File: rtl/timer_prescaler.sv
// Clock divider for the timer: emits a one-cycle tick every PRESCALE enabled cycles.
module timer_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(PRESCALE - 1);

    logic [15:0] pcnt_q, pcnt_d;

    // Tick on the last count of a phase; disable or a TL write restarts the phase.
    always_comb begin
        tick   = en & (pcnt_q == LAST);
        pcnt_d = pcnt_q;
        if (!en || clr)
            pcnt_d = 16'd0;
        else if (tick)
            pcnt_d = 16'd0;
        else
            pcnt_d = pcnt_q + 16'd1;
    end

    // Prescaler count register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pcnt_q <= 16'd0;
        else
            pcnt_q <= pcnt_d;
    end

endmodule

// File: rtl/bus_timer.sv
// 32-bit reload timer on the data bus: TH (reload), TL (counter), TCON (control/status).
module bus_timer
    import bus_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int          PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] Write_data,
    output logic [31:0] Read_data,
    output logic        irq
);

    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic        en_q, en_d;
    logic        irqen_q, irqen_d;
    logic        status_q, status_d;
    logic        irq_q, irq_d;

    logic sel_th, sel_tl, sel_tcon;
    logic wr_th, wr_tl, wr_tcon;
    logic tick, ovf;

    assign sel_th   = (Address == BASE_ADDR + TH_OFF);
    assign sel_tl   = (Address == BASE_ADDR + TL_OFF);
    assign sel_tcon = (Address == BASE_ADDR + TCON_OFF);

    assign wr_th    = MemWrite & sel_th;
    assign wr_tl    = MemWrite & sel_tl;
    assign wr_tcon  = MemWrite & sel_tcon;

    timer_prescaler #(.PRESCALE(PRESCALE)) u_presc (
        .clk   (clk),
        .reset (reset),
        .en    (en_q),
        .clr   (wr_tl),
        .tick  (tick)
    );

    // A CPU write to TL suppresses the overflow of that cycle entirely.
    assign ovf = tick & ~wr_tl & (tl_q == 32'hFFFF_FFFF);

    // Next-state for the register file; overflow beats a status-clear write.
    always_comb begin
        th_d     = wr_th ? Write_data : th_q;

        tl_d     = tl_q;
        if (wr_tl)
            tl_d = Write_data;
        else if (tick)
            tl_d = ovf ? th_q : tl_q + 32'd1;

        en_d     = wr_tcon ? Write_data[EN_BIT]    : en_q;
        irqen_d  = wr_tcon ? Write_data[IRQEN_BIT] : irqen_q;

        status_d = status_q;
        if (wr_tcon && !Write_data[STATUS_BIT])
            status_d = 1'b0;
        if (ovf && irqen_q)
            status_d = 1'b1;

        // irq lags status by one edge
        irq_d    = irqen_q & status_q;
    end

    // Register file state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            th_q     <= 32'd0;
            tl_q     <= 32'd0;
            en_q     <= 1'b0;
            irqen_q  <= 1'b0;
            status_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            th_q     <= th_d;
            tl_q     <= tl_d;
            en_q     <= en_d;
            irqen_q  <= irqen_d;
            status_q <= status_d;
            irq_q    <= irq_d;
        end
    end

    assign irq = irq_q;

    // Combinational read mux; zero when not selected so it can be ORed onto the bus.
    always_comb begin
        Read_data = 32'd0;
        if (MemRead) begin
            if (sel_th)
                Read_data = th_q;
            else if (sel_tl)
                Read_data = tl_q;
            else if (sel_tcon)
                Read_data = {29'd0, status_q, irqen_q, en_q};
        end
    end

endmodule

// File: tb/tb_bus_timer.sv
// Self-checking bench for bus_timer: one instance with PRESCALE=1, one with PRESCALE=4.
module tb_bus_timer;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [31:0] A_TH = BASE;
    localparam logic [31:0] A_TL = BASE + 32'd4;
    localparam logic [31:0] A_TC = BASE + 32'd8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] Address = 32'd0;
    logic [31:0] Write_data = 32'd0;
    logic [31:0] rd1, rd4;
    logic        irq1, irq4;

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    bus_timer #(.BASE_ADDR(BASE), .PRESCALE(1)) dut1 (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .Address(Address), .Write_data(Write_data), .Read_data(rd1), .irq(irq1)
    );

    bus_timer #(.BASE_ADDR(BASE), .PRESCALE(4)) dut4 (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .Address(Address), .Write_data(Write_data), .Read_data(rd4), .irq(irq4)
    );

    // kind: 0 = write, 1 = read with MemRead, 2 = read with MemRead low
    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called at a negedge; write captured on the next posedge, returns at the following negedge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        MemWrite   = 1'b1;
        Address    = a;
        Write_data = d;
        @(negedge clk);
        MemWrite   = 1'b0;
        Address    = 32'd0;
    endtask

    task automatic rdchk(input string nm, input int which, input logic [31:0] a,
                         input logic [31:0] exp);
        MemRead = 1'b1;
        Address = a;
        #1;
        chk(nm, (which == 4) ? rd4 : rd1, exp);
        MemRead = 1'b0;
        Address = 32'd0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        tbl[0]  = '{0, A_TC, 32'h0000_0000};
        tbl[1]  = '{0, A_TH, 32'h1234_5678};
        tbl[2]  = '{1, A_TH, 32'h1234_5678};
        tbl[3]  = '{0, A_TL, 32'hA5A5_A5A5};
        tbl[4]  = '{1, A_TL, 32'hA5A5_A5A5};
        tbl[5]  = '{0, BASE + 32'd12, 32'hDEAD_BEEF};
        tbl[6]  = '{0, 32'h4000_000C, 32'hDEAD_BEEF};
        tbl[7]  = '{0, BASE + 32'd1, 32'hDEAD_BEEF};
        tbl[8]  = '{0, BASE + 32'd6, 32'hDEAD_BEEF};
        tbl[9]  = '{1, A_TH, 32'h1234_5678};
        tbl[10] = '{1, A_TL, 32'hA5A5_A5A5};
        tbl[11] = '{1, A_TC, 32'h0000_0000};
        tbl[12] = '{1, BASE + 32'd12, 32'h0000_0000};
        tbl[13] = '{2, A_TH, 32'h0000_0000};
        tbl[14] = '{0, A_TC, 32'hFFFF_FFFE};
        tbl[15] = '{1, A_TC, 32'h0000_0002};

        // Power-on reset
        cyc(2);
        reset = 1'b0;
        cyc(1);

        // Reset mid-count
        wr(A_TL, 32'h0000_1234);
        wr(A_TH, 32'h0000_0055);
        wr(A_TC, 32'h0000_0003);
        cyc(2);
        #2 reset = 1'b1;
        rdchk("rst_tl", 1, A_TL, 32'h0);
        rdchk("rst_th", 1, A_TH, 32'h0);
        rdchk("rst_tcon", 1, A_TC, 32'h0);
        chk("rst_irq", {31'd0, irq1}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        cyc(3);
        rdchk("rst_tl_hold", 1, A_TL, 32'h0);

        // Overflow with interrupt (PRESCALE=1); E is the TCON write edge
        wr(A_TH, 32'hFFFF_FFFC);
        wr(A_TL, 32'hFFFF_FFFE);
        wr(A_TC, 32'h0000_0003);
        rdchk("ovf_tl_e0", 1, A_TL, 32'hFFFF_FFFE);
        cyc(1);
        rdchk("ovf_tl_e1", 1, A_TL, 32'hFFFF_FFFF);
        rdchk("ovf_tcon_e1", 1, A_TC, 32'h3);
        cyc(1);
        rdchk("ovf_reload", 1, A_TL, 32'hFFFF_FFFC);
        rdchk("ovf_status", 1, A_TC, 32'h7);
        chk("ovf_irq_e2", {31'd0, irq1}, 32'h0);
        cyc(1);
        chk("ovf_irq_e3", {31'd0, irq1}, 32'h1);
        rdchk("ovf_tl_e3", 1, A_TL, 32'hFFFF_FFFD);

        // Interrupt clear at E+4
        wr(A_TC, 32'h0000_0003);
        rdchk("clr_tcon", 1, A_TC, 32'h3);
        chk("clr_irq_e4", {31'd0, irq1}, 32'h1);
        cyc(1);
        chk("clr_irq_e5", {31'd0, irq1}, 32'h0);

        // Overflow beats clear: overflow at E+6, clear lands on overflow E+10
        cyc(2);
        chk("re_irq_e7", {31'd0, irq1}, 32'h1);
        cyc(2);
        wr(A_TC, 32'h0000_0003);
        rdchk("race_tcon", 1, A_TC, 32'h7);
        rdchk("race_tl", 1, A_TL, 32'hFFFF_FFFC);
        chk("race_irq_e10", {31'd0, irq1}, 32'h1);
        cyc(1);
        chk("race_irq_e11", {31'd0, irq1}, 32'h1);

        // TL write on the overflow tick wins, no status set
        wr(A_TC, 32'h0000_0003);
        cyc(1);
        rdchk("tlw_pre", 1, A_TL, 32'hFFFF_FFFF);
        wr(A_TL, 32'h0000_0005);
        rdchk("tlw_tl", 1, A_TL, 32'h0000_0005);
        rdchk("tlw_tcon", 1, A_TC, 32'h3);

        // TH write on overflow edge: reload uses the old TH
        wr(A_TL, 32'hFFFF_FFFF);
        wr(A_TH, 32'h0000_0100);
        rdchk("thw_tl", 1, A_TL, 32'hFFFF_FFFC);
        rdchk("thw_th", 1, A_TH, 32'h0000_0100);
        rdchk("thw_tcon", 1, A_TC, 32'h7);
        cyc(4);
        rdchk("thw_next", 1, A_TL, 32'h0000_0100);

        // Register access and decode isolation table
        for (int i = 0; i < 16; i++) begin
            if (tbl[i].kind == 0) begin
                wr(tbl[i].addr, tbl[i].data);
            end else begin
                MemRead = (tbl[i].kind == 1);
                Address = tbl[i].addr;
                #1;
                chk($sformatf("tbl[%0d]", i), rd1, tbl[i].data);
                MemRead = 1'b0;
                Address = 32'd0;
                @(negedge clk);
            end
        end

        // Prescaler (PRESCALE=4 instance)
        wr(A_TL, 32'h0);
        wr(A_TC, 32'h1);
        cyc(15);
        rdchk("psc_tl15", 4, A_TL, 32'd3);
        cyc(1);
        rdchk("psc_tl16", 4, A_TL, 32'd4);
        wr(A_TL, 32'd10);
        rdchk("psc_wr", 4, A_TL, 32'd10);
        cyc(3);
        rdchk("psc_hold", 4, A_TL, 32'd10);
        cyc(1);
        rdchk("psc_tl11", 4, A_TL, 32'd11);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
